// File: rtl/movement_controller.sv
// movement_controller
// Tile-locked overworld movement: turns the USB keycode into facing/walking
// state, advances the camera offsets once per video frame, and produces the
// walk animation phase.
//
// Ports
//   Clk, Reset        : system clock, synchronous active-high reset
//   VS                : VGA vertical sync (asynchronous), paces all movement
//   Keycode[7:0]      : USB HID keycode (W/A/S/D mapped, anything else = none)
//   Character_Moving  : high while walking
//   Direction[1:0]    : facing, 0=up 1=right 2=down 3=left
//   TopLeftX/Y[10:0]  : camera offsets
//   AnimFrame[1:0]    : walk animation phase
//   FrameTick         : one-cycle pulse per VS rising edge
module movement_controller #(
   parameter int TILE_PX     = 16,
   parameter int SPEED       = 1,
   parameter int TURN_FRAMES = 4,
   parameter int ANIM_DIV    = 4,
   parameter int INIT_X      = 100,
   parameter int INIT_Y      = 100,
   parameter int MAX_X       = 960,
   parameter int MAX_Y       = 720
) (
   input  logic        Clk,
   input  logic        Reset,
   input  logic        VS,
   input  logic [7:0]  Keycode,
   output logic        Character_Moving,
   output logic [1:0]  Direction,
   output logic [10:0] TopLeftX,
   output logic [10:0] TopLeftY,
   output logic [1:0]  AnimFrame,
   output logic        FrameTick
);

   localparam int SW = $clog2(TILE_PX + 1);
   localparam int TW = $clog2(TURN_FRAMES + 1);
   localparam int AW = $clog2(ANIM_DIV + 1);

   localparam logic [SW-1:0] SPEED_S   = SW'(SPEED);
   localparam logic [SW-1:0] TILE_S    = SW'(TILE_PX);
   localparam logic [TW-1:0] TURN_INIT = TW'(TURN_FRAMES - 1);
   localparam logic [AW-1:0] ANIM_LAST = AW'(ANIM_DIV - 1);
   localparam logic [10:0]   SPEED_P   = 11'(SPEED);
   localparam logic [11:0]   TILE12    = 12'(TILE_PX);
   localparam logic [11:0]   MAXX12    = 12'(MAX_X);
   localparam logic [11:0]   MAXY12    = 12'(MAX_Y);

   typedef enum logic [1:0] {S_IDLE, S_TURN, S_WALK} state_t;

   state_t         state_q, state_d;
   logic [1:0]     dir_q, dir_d;
   logic [10:0]    x_q, x_d, y_q, y_d;
   logic [SW-1:0]  step_q, step_d;
   logic [TW-1:0]  turn_q, turn_d;
   logic [AW-1:0]  div_q, div_d;
   logic [1:0]     anim_q, anim_d;
   logic           moving_q, moving_d;
   logic           vs_s1_q, vs_s2_q, vs_s3_q;
   logic           tick_q, tick_d;

   logic           key_valid;
   logic [1:0]     key_dir;

   // Widened to 12 bits so offset + tile never wraps.
   function automatic logic blocked(input logic [1:0] d, input logic [10:0] x,
                                    input logic [10:0] y);
      logic [11:0] x12, y12;
      x12 = {1'b0, x};
      y12 = {1'b0, y};
      case (d)
         2'd0:    blocked = y12 < TILE12;
         2'd1:    blocked = (x12 + TILE12) > MAXX12;
         2'd2:    blocked = (y12 + TILE12) > MAXY12;
         default: blocked = x12 < TILE12;
      endcase
   endfunction

   always_comb begin
      key_valid = 1'b1;
      key_dir   = 2'd0;
      case (Keycode)
         8'h1A:   key_dir = 2'd0;
         8'h07:   key_dir = 2'd1;
         8'h16:   key_dir = 2'd2;
         8'h04:   key_dir = 2'd3;
         default: key_valid = 1'b0;
      endcase
   end

   // Synchronizer stage 3 holds the previous synchronized VS for edge detect.
   assign tick_d = vs_s2_q & ~vs_s3_q;

   always_comb begin
      state_d  = state_q;
      dir_d    = dir_q;
      x_d      = x_q;
      y_d      = y_q;
      step_d   = step_q;
      turn_d   = turn_q;
      div_d    = div_q;
      anim_d   = anim_q;
      moving_d = moving_q;
      if (tick_q) begin
         case (state_q)
            S_IDLE: begin
               if (key_valid) begin
                  if (key_dir != dir_q) begin
                     dir_d   = key_dir;
                     turn_d  = TURN_INIT;
                     state_d = S_TURN;
                  end else if (!blocked(dir_q, x_q, y_q)) begin
                     step_d  = '0;
                     state_d = S_WALK;
                  end
               end
            end
            S_TURN: begin
               // Key changes here never retarget the facing direction.
               if (turn_q != '0) begin
                  turn_d = turn_q - 1'b1;
               end else if (key_valid && key_dir == dir_q && !blocked(dir_q, x_q, y_q)) begin
                  step_d  = '0;
                  state_d = S_WALK;
               end else begin
                  state_d = S_IDLE;
               end
            end
            S_WALK: begin
               case (dir_q)
                  2'd0:    y_d = y_q - SPEED_P;
                  2'd1:    x_d = x_q + SPEED_P;
                  2'd2:    y_d = y_q + SPEED_P;
                  default: x_d = x_q - SPEED_P;
               endcase
               // The key only matters at the tile boundary; mid-step it is ignored.
               if (step_q + SPEED_S == TILE_S) begin
                  step_d = '0;
                  if (key_valid && key_dir == dir_q && !blocked(dir_q, x_d, y_d)) begin
                     state_d = S_WALK;
                  end else if (key_valid && key_dir != dir_q) begin
                     dir_d   = key_dir;
                     turn_d  = TURN_INIT;
                     state_d = S_TURN;
                  end else begin
                     state_d = S_IDLE;
                  end
               end else begin
                  step_d = step_q + SPEED_S;
               end
            end
            default: state_d = S_IDLE;
         endcase

         // Animation only advances on ticks spent walking; entry tick keeps phase 0.
         if (state_d != S_WALK) begin
            div_d  = '0;
            anim_d = 2'd0;
         end else if (state_q == S_WALK) begin
            if (div_q == ANIM_LAST) begin
               div_d  = '0;
               anim_d = anim_q + 2'd1;
            end else begin
               div_d = div_q + 1'b1;
            end
         end
         moving_d = (state_d == S_WALK);
      end
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         state_q  <= S_IDLE;
         dir_q    <= 2'd2;
         x_q      <= 11'(INIT_X);
         y_q      <= 11'(INIT_Y);
         step_q   <= '0;
         turn_q   <= '0;
         div_q    <= '0;
         anim_q   <= 2'd0;
         moving_q <= 1'b0;
         vs_s1_q  <= 1'b0;
         vs_s2_q  <= 1'b0;
         vs_s3_q  <= 1'b0;
         tick_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         dir_q    <= dir_d;
         x_q      <= x_d;
         y_q      <= y_d;
         step_q   <= step_d;
         turn_q   <= turn_d;
         div_q    <= div_d;
         anim_q   <= anim_d;
         moving_q <= moving_d;
         vs_s1_q  <= VS;
         vs_s2_q  <= vs_s1_q;
         vs_s3_q  <= vs_s2_q;
         tick_q   <= tick_d;
      end
   end

   assign Character_Moving = moving_q;
   assign Direction        = dir_q;
   assign TopLeftX         = x_q;
   assign TopLeftY         = y_q;
   assign AnimFrame        = anim_q;
   assign FrameTick        = tick_q;

endmodule
